// File: rtl/canvas_scanner.sv
// ============================================================================
// canvas_scanner : row-major raster read-out of the canvas memory onto a
//                  valid/ready pixel stream with frame/line markers.  Rev 1.0
// ============================================================================
`default_nettype none

module canvas_scanner #(
  parameter int ImageWidth  = 10,
  parameter int ImageHeight = 5,
  parameter int ColorBits   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  output logic [8:0]           XRead,
  output logic [7:0]           YRead,
  input  logic [ColorBits-1:0] readValueMemory,
  output logic                 pixel_valid,
  input  logic                 pixel_ready,
  output logic [ColorBits-1:0] pixel_color,
  output logic [8:0]           pixel_x,
  output logic [7:0]           pixel_y,
  output logic                 start_of_frame,
  output logic                 end_of_line,
  output logic                 end_of_frame,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [8:0] XLast = 9'(ImageWidth - 1);
  localparam logic [7:0] YLast = 8'(ImageHeight - 1);

  state_t               state_q, state_d;
  logic [8:0]           x_q, x_d;
  logic [7:0]           y_q, y_d;
  logic [ColorBits-1:0] color_q, color_d;
  logic [8:0]           px_q, px_d;
  logic [7:0]           py_q, py_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic                 eof_q, eof_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // x_q/y_q only move when entering READ, so they double as the held read address.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    px_d    = px_q;
    py_d    = py_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        color_d = readValueMemory;
        px_d    = x_q;
        py_d    = y_q;
        sof_d   = (x_q == 9'd0) && (y_q == 8'd0);
        eol_d   = (x_q == XLast);
        eof_d   = (x_q == XLast) && (y_q == YLast);
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (pixel_ready) begin
          valid_d = 1'b0;
          if (eof_q) begin
            done_d = 1'b1;
            if (continuous) begin
              x_d     = '0;
              y_d     = '0;
              state_d = S_READ;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            if (x_q == XLast) begin
              x_d = '0;
              y_d = y_q + 8'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
            state_d = S_READ;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign XRead          = x_q;
  assign YRead          = y_q;
  assign pixel_valid    = valid_q;
  assign pixel_color    = color_q;
  assign pixel_x        = px_q;
  assign pixel_y        = py_q;
  assign start_of_frame = sof_q;
  assign end_of_line    = eol_q;
  assign end_of_frame   = eof_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

`default_nettype wire
